// File: rtl/maze_path_replayer.sv
// Replays a solver move stream from the start cell and emits every visited cell.
// Define REPLAY_VISIT_CHECK_EN to add a visited-cell map that rejects path loops.
module maze_path_replayer #(
  parameter int WIDTH   = 4,
  parameter int START_I = 0,
  parameter int START_J = 0,
  parameter int GOAL_I  = 15,
  parameter int GOAL_J  = 15,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             moveValid,
  input  logic [1:0]       move,
  input  logic             moveLast,
  output logic             moveReady,
  output logic             posValid,
  output logic [WIDTH-1:0] posI,
  output logic [WIDTH-1:0] posJ,
  input  logic             posReady,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] stepCount
);

  localparam logic [WIDTH-1:0] START_I_W = WIDTH'(START_I);
  localparam logic [WIDTH-1:0] START_J_W = WIDTH'(START_J);
  localparam logic [WIDTH-1:0] GOAL_I_W  = WIDTH'(GOAL_I);
  localparam logic [WIDTH-1:0] GOAL_J_W  = WIDTH'(GOAL_J);
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, EMIT, WAIT, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_i_q, pos_i_d, pos_j_q, pos_j_d;
  logic [WIDTH-1:0] next_i, next_j;
  logic [CNT_W-1:0] step_q, step_d;
  logic             last_q, last_d;
  logic             oob, revisit;
  logic             move_ready_q, move_ready_d;
  logic             pos_valid_q, pos_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

`ifdef REPLAY_VISIT_CHECK_EN
  localparam int CELLS = 1 << (2 * WIDTH);
  logic [CELLS-1:0]   visited_q, visited_d;
  logic [2*WIDTH-1:0] tgt_idx;
  assign tgt_idx = {next_i, next_j};
  assign revisit = visited_q[tgt_idx];
`else
  assign revisit = 1'b0;
`endif

  // Target cell of the offered move; oob flags a step off the grid edge.
  always_comb begin
    next_i = pos_i_q;
    next_j = pos_j_q;
    oob    = 1'b0;
    case (move)
      2'b00: begin next_j = pos_j_q + ONE_W; oob = &pos_j_q;  end
      2'b01: begin next_i = pos_i_q + ONE_W; oob = &pos_i_q;  end
      2'b10: begin next_j = pos_j_q - ONE_W; oob = ~|pos_j_q; end
      default: begin next_i = pos_i_q - ONE_W; oob = ~|pos_i_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pos_i_d = pos_i_q;
    pos_j_d = pos_j_q;
    step_d  = step_q;
    last_d  = last_q;
`ifdef REPLAY_VISIT_CHECK_EN
    visited_d = visited_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_d = EMIT;
          pos_i_d = START_I_W;
          pos_j_d = START_J_W;
          step_d  = '0;
          last_d  = 1'b0;
`ifdef REPLAY_VISIT_CHECK_EN
          visited_d = '0;
          visited_d[{START_I_W, START_J_W}] = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (posReady) begin
          if (pos_i_q == GOAL_I_W && pos_j_q == GOAL_J_W) state_d = DONE;
          else if (last_q)                                 state_d = ERR;
          else                                             state_d = WAIT;
        end
      end
      WAIT: begin
        // Rejections leave position and step count untouched.
        if (moveValid) begin
          if (oob || revisit || (&step_q)) begin
            state_d = ERR;
          end else begin
            state_d = EMIT;
            pos_i_d = next_i;
            pos_j_d = next_j;
            step_d  = step_q + ONE_C;
            last_d  = moveLast;
`ifdef REPLAY_VISIT_CHECK_EN
            visited_d[tgt_idx] = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    move_ready_d = (state_d == WAIT);
    pos_valid_d  = (state_d == EMIT);
    busy_d       = (state_d == EMIT) || (state_d == WAIT);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      pos_i_q      <= START_I_W;
      pos_j_q      <= START_J_W;
      step_q       <= '0;
      last_q       <= 1'b0;
      move_ready_q <= 1'b0;
      pos_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef REPLAY_VISIT_CHECK_EN
      visited_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pos_i_q      <= pos_i_d;
      pos_j_q      <= pos_j_d;
      step_q       <= step_d;
      last_q       <= last_d;
      move_ready_q <= move_ready_d;
      pos_valid_q  <= pos_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef REPLAY_VISIT_CHECK_EN
      visited_q    <= visited_d;
`endif
    end
  end

  assign moveReady = move_ready_q;
  assign posValid  = pos_valid_q;
  assign posI      = pos_i_q;
  assign posJ      = pos_j_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign stepCount = step_q;

endmodule

// File: tb/tb_maze_path_replayer.sv
// Randomized self-checking bench for maze_path_replayer against a path-walk reference model.
module tb_maze_path_replayer;

  localparam int WIDTH = 4, CNT_W = 8, G = 1 << WIDTH;
  localparam int START_I = 0, START_J = 0, GOAL_I = 15, GOAL_J = 15;
  localparam int MAXSTEP = (1 << CNT_W) - 1;
  localparam int BUDGET = 6000;
  localparam int OUT_DONE = 0, OUT_ERR = 1, OUT_STALL = 2;

  logic             CLK = 1'b0;
  logic             RST, Start, moveValid, moveLast, posReady;
  logic [1:0]       move;
  logic             moveReady, posValid, Busy, Done, Error;
  logic [WIDTH-1:0] posI, posJ;
  logic [CNT_W-1:0] stepCount;

  int    checks = 0, errors = 0;
  int    mv[512];
  bit    ml[512];
  int    exp_i[$], exp_j[$];
  int    exp_outcome, exp_steps, exp_consumed, exp_fi, exp_fj, n_emit;
  string cur_name = "init";

  maze_path_replayer #(
    .WIDTH(WIDTH), .START_I(START_I), .START_J(START_J),
    .GOAL_I(GOAL_I), .GOAL_J(GOAL_J), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .moveValid(moveValid), .move(move),
    .moveLast(moveLast), .moveReady(moveReady), .posValid(posValid),
    .posI(posI), .posJ(posJ), .posReady(posReady), .Busy(Busy), .Done(Done),
    .Error(Error), .stepCount(stepCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached in %s", cur_name);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur_name, name, act, expv);
    end
  endtask

  // Walks the move list by the path rules and records every cell that must be emitted.
  task automatic model(input int n);
    int pi, pj, ni, nj, k;
    bit lastf, stop;
`ifdef REPLAY_VISIT_CHECK_EN
    bit vis[int];
`endif
    pi = START_I; pj = START_J; k = 0; lastf = 0; stop = 0; exp_steps = 0;
    exp_i.delete(); exp_j.delete();
    exp_i.push_back(pi); exp_j.push_back(pj);
`ifdef REPLAY_VISIT_CHECK_EN
    vis[pi * G + pj] = 1'b1;
`endif
    while (!stop) begin
      if (pi == GOAL_I && pj == GOAL_J) begin exp_outcome = OUT_DONE; stop = 1; end
      else if (lastf) begin exp_outcome = OUT_ERR; stop = 1; end
      else if (k >= n) begin exp_outcome = OUT_STALL; stop = 1; end
      else begin
        ni = pi; nj = pj;
        case (mv[k])
          0: nj = pj + 1;
          1: ni = pi + 1;
          2: nj = pj - 1;
          default: ni = pi - 1;
        endcase
        k++;
        if (ni < 0 || ni >= G || nj < 0 || nj >= G) begin exp_outcome = OUT_ERR; stop = 1; end
`ifdef REPLAY_VISIT_CHECK_EN
        else if (vis.exists(ni * G + nj)) begin exp_outcome = OUT_ERR; stop = 1; end
`endif
        else if (exp_steps == MAXSTEP) begin exp_outcome = OUT_ERR; stop = 1; end
        else begin
          pi = ni; pj = nj; exp_steps++; lastf = ml[k-1];
          exp_i.push_back(pi); exp_j.push_back(pj);
`ifdef REPLAY_VISIT_CHECK_EN
          vis[pi * G + pj] = 1'b1;
`endif
        end
      end
    end
    exp_consumed = k; exp_fi = pi; exp_fj = pj;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; Start = 0; moveValid = 0;
    @(negedge CLK);
    RST = 0;
    chk("rst_posValid", posValid, 0);
    chk("rst_moveReady", moveReady, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_steps", stepCount, 0);
    chk("rst_posI", posI, START_I);
    chk("rst_posJ", posJ, START_J);
  endtask

  task automatic run_replay(input string name, input int n, input int rmode, input bit mid_start);
    int idx, cyc, pi_, pj_;
    bit fin, pv, pr, pacc;
    cur_name = name;
    idx = 0; cyc = 0; fin = 0; pv = 0; pr = 1; pacc = 0; pi_ = 0; pj_ = 0;
    model(n);
    n_emit = 0;
    @(negedge CLK);
    Start = 1; moveValid = 0;
    while (!fin && cyc < BUDGET) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        chk("start_steps", stepCount, 0);
        chk("start_done", Done, 0);
        chk("start_error", Error, 0);
        chk("start_valid", posValid, 1);
        chk("start_posI", posI, START_I);
        chk("start_posJ", posJ, START_J);
      end
      if (pv && !pr) begin
        chk("hold_valid", posValid, 1);
        chk("hold_posI", posI, pi_);
        chk("hold_posJ", posJ, pj_);
      end
      if (pacc) chk("accept_latency", posValid | Error, 1);
      chk("ready_in_emit", posValid & moveReady, 0);
      if (Done || Error) fin = 1;
      else if (exp_outcome == OUT_STALL && idx == n && exp_i.size() == 0 && moveReady) fin = 1;

      case (rmode)
        0: posReady = 1;
        1: posReady = (cyc % 3 == 1);
        default: posReady = 1'($urandom_range(0, 1));
      endcase
      Start = mid_start && Busy && ($urandom_range(0, 7) == 0);
      if (!fin && idx < n && $urandom_range(0, 9) < 7) begin
        moveValid = 1; move = 2'(mv[idx]); moveLast = ml[idx];
      end else begin
        moveValid = 0; move = 2'($urandom); moveLast = 1'($urandom);
      end

      pacc = moveValid && moveReady;
      if (pacc) idx++;
      if (posValid && posReady) begin
        if (exp_i.size() == 0) chk("extra_coord", exp_i.size(), 1);
        else begin
          chk("coord_i", posI, exp_i.pop_front());
          chk("coord_j", posJ, exp_j.pop_front());
          n_emit++;
        end
      end
      pv = posValid; pr = posReady; pi_ = posI; pj_ = posJ;
    end
    Start = 0; moveValid = 0;
    chk("finish_in_budget", int'(fin), 1);
    chk("final_done", Done, int'(exp_outcome == OUT_DONE));
    chk("final_error", Error, int'(exp_outcome == OUT_ERR));
    chk("final_busy", Busy, int'(exp_outcome == OUT_STALL));
    chk("final_moveReady", moveReady, int'(exp_outcome == OUT_STALL));
    chk("final_steps", stepCount, exp_steps);
    chk("moves_consumed", idx, exp_consumed);
    chk("coords_left", exp_i.size(), 0);
    chk("final_posI", posI, exp_fi);
    chk("final_posJ", posJ, exp_fj);
    $display("replay %s: moves=%0d consumed=%0d steps=%0d coords=%0d done=%0b error=%0b cycles=%0d",
             name, n, idx, stepCount, n_emit, Done, Error, cyc);
    exp_i.delete(); exp_j.delete();
  endtask

  task automatic settle();
    if (exp_outcome == OUT_STALL) do_reset();
  endtask

  task automatic load_straight();
    for (int k = 0; k < 30; k++) begin
      mv[k] = (k < 15) ? 0 : 1;
      ml[k] = (k == 29);
    end
  endtask

  initial begin
    RST = 1; Start = 0; moveValid = 0; move = 0; moveLast = 0; posReady = 0;
    do_reset();

    load_straight();
    run_replay("straight", 30, 0, 0);
    chk("lit_straight_steps", stepCount, 30);
    chk("lit_straight_done", Done, 1);
    chk("lit_straight_error", Error, 0);
    chk("lit_straight_coords", n_emit, 31);
    chk("lit_straight_posI", posI, 15);
    chk("lit_straight_posJ", posJ, 15);

    run_replay("backpressure", 30, 1, 0);
    chk("lit_bp_coords", n_emit, 31);
    chk("lit_bp_done", Done, 1);

    run_replay("mid_start", 30, 2, 1);
    chk("lit_mid_coords", n_emit, 31);

    mv[0] = 3; ml[0] = 0;
    run_replay("out_of_bounds", 1, 0, 0);
    chk("lit_oob_error", Error, 1);
    chk("lit_oob_posI", posI, 0);
    chk("lit_oob_posJ", posJ, 0);
    chk("lit_oob_steps", stepCount, 0);
    chk("lit_oob_ready", moveReady, 0);

    mv[0] = 0; ml[0] = 0; mv[1] = 0; ml[1] = 1;
    run_replay("short_path", 2, 2, 0);
    chk("lit_short_error", Error, 1);
    chk("lit_short_done", Done, 0);
    chk("lit_short_coords", n_emit, 3);
    chk("lit_short_posJ", posJ, 2);

    mv[0] = 0; ml[0] = 0; mv[1] = 2; ml[1] = 0;
    run_replay("revisit", 2, 0, 0);
`ifdef REPLAY_VISIT_CHECK_EN
    chk("lit_visit_error", Error, 1);
    chk("lit_visit_posI", posI, 0);
    chk("lit_visit_posJ", posJ, 1);
    chk("lit_visit_steps", stepCount, 1);
`else
    chk("lit_visit_error", Error, 0);
    chk("lit_visit_posI", posI, 0);
    chk("lit_visit_posJ", posJ, 0);
    chk("lit_visit_steps", stepCount, 2);
`endif
    settle();

    for (int k = 0; k < 256; k++) begin
      mv[k] = (k % 2 == 0) ? 0 : 2;
      ml[k] = 0;
    end
    run_replay("overflow", 256, 0, 0);
`ifndef REPLAY_VISIT_CHECK_EN
    chk("lit_ovf_error", Error, 1);
    chk("lit_ovf_steps", stepCount, 255);
`endif
    settle();

    // Reset while a coordinate is being offered.
    cur_name = "rst_in_emit";
    @(negedge CLK);
    Start = 1; posReady = 0;
    @(negedge CLK);
    Start = 0;
    chk("emit_valid_before_rst", posValid, 1);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("rst_emit_valid", posValid, 0);
    chk("rst_emit_busy", Busy, 0);
    chk("rst_emit_steps", stepCount, 0);
    chk("rst_emit_ready", moveReady, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("idle_valid", posValid, 0);
      chk("idle_ready", moveReady, 0);
      chk("idle_busy", Busy, 0);
    end
    $display("replay rst_in_emit: reset during EMIT returned to idle");

    for (int r = 0; r < 40; r++) begin
      int n, rr;
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        rr = $urandom_range(0, 9);
        mv[k] = (rr < 4) ? 0 : (rr < 8) ? 1 : (rr == 8) ? 2 : 3;
        ml[k] = 0;
      end
      if ($urandom_range(0, 3) != 0) ml[n-1] = 1;
      run_replay($sformatf("random_%0d", r), n, $urandom_range(0, 2), bit'($urandom_range(0, 1)));
      settle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
